// File: rtl/warblade_enemy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : warblade_enemy_pkg
// Purpose  : Shared constants, FSM state type and fire-interval helper for
//            the enemy formation blocks.
// Revision : 1.0 - initial release
// ============================================================================
package warblade_enemy_pkg;

  localparam int N_ENEMIES = 5;
  localparam int N_SLOTS   = 3;
  localparam int COORD_W   = 11;

  typedef enum logic [1:0] {
    COUNT  = 2'd0,
    PICK   = 2'd1,
    SLOT   = 2'd2,
    LAUNCH = 2'd3
  } fire_state_t;

  // Frames between shots: base - level*step, never below min_iv.
  // A product larger than base (negative difference) also lands on min_iv.
  function automatic logic [7:0] fire_interval(input logic [3:0] level,
                                               input logic [7:0] base,
                                               input logic [7:0] step,
                                               input logic [7:0] min_iv);
    logic [11:0] prod;
    prod = {8'd0, level} * {4'd0, step};
    if ({4'd0, base} < (prod + {4'd0, min_iv}))
      return min_iv;
    else
      return base - prod[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick5.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick5
// Purpose  : Combinational round-robin selector over five requesters. The
//            search starts at (ptr+1) mod 5 and wraps.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick5
  import warblade_enemy_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  // Walk the candidates farthest-first so the nearest one after ptr wins.
  always_comb begin
    int w_idx;
    gnt_idx   = 3'd0;
    gnt_valid = 1'b0;
    w_idx     = 0;
    for (int i = N_ENEMIES; i >= 1; i--) begin
      w_idx = (int'(ptr) + i) % N_ENEMIES;
      if (req[w_idx]) begin
        gnt_idx   = 3'(w_idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/enemy_fire_sched.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_sched
// Purpose  : Enemy return-fire scheduler. Counts frames per level-dependent
//            interval, picks a shooter and a free missile slot, and issues a
//            one-cycle launch command with the launch coordinates.
// Options  : ENEMY_FIRE_AIMED_EN - pick the enemy closest to player_x
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_fire_sched
  import warblade_enemy_pkg::*;
#(
  parameter int FIRE_BASE = 90,
  parameter int FIRE_STEP = 8,
  parameter int FIRE_MIN  = 20,
  parameter int X_OFFSET  = 16,
  parameter int Y_OFFSET  = 32,
  parameter int GRACE     = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [3:0]  level_in,
  input  logic [4:0]  alive,
  input  logic [54:0] en_xpos,
  input  logic [54:0] en_ypos,
  input  logic [2:0]  slot_busy,
  input  logic [10:0] player_x,
  output logic        launch_valid,
  output logic [1:0]  launch_slot,
  output logic [2:0]  launch_src,
  output logic [10:0] launch_x,
  output logic [10:0] launch_y,
  output logic        fire_pending
);

  localparam int GW = (GRACE < 2) ? 1 : $clog2(GRACE + 1);

  fire_state_t        r_state, w_state_next;
  logic               r_vsync_q;
  logic [3:0]         r_level_q;
  logic [7:0]         r_counter;
  logic [2:0]         r_ptr, r_src;
  logic [1:0]         r_slot;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_retry;
  logic [GW-1:0]      r_grace [N_SLOTS];

  logic               w_tick, w_level_chg, w_pick_ok, w_slot_ok;
  logic [7:0]         w_interval;
  logic [2:0]         w_pick_idx, w_rr_idx;
  logic               w_pick_valid, w_rr_valid;
  logic [1:0]         w_free_idx;
  logic [COORD_W-1:0] w_ex [N_ENEMIES];
  logic [COORD_W-1:0] w_ey [N_ENEMIES];
  logic [11:0]        w_sum_x, w_sum_y;
  logic               w_unused;

  assign w_tick      = vsync_in & ~r_vsync_q;
  assign w_level_chg = (level_in != r_level_q);
  assign w_interval  = fire_interval(level_in, 8'(FIRE_BASE), 8'(FIRE_STEP), 8'(FIRE_MIN));

  generate
    for (genvar i = 0; i < N_ENEMIES; i++) begin : g_unpack
      assign w_ex[i] = en_xpos[COORD_W*i +: COORD_W];
      assign w_ey[i] = en_ypos[COORD_W*i +: COORD_W];
    end
  endgenerate

  rr_pick5 u_rr_pick5 (
    .req       (alive),
    .ptr       (r_ptr),
    .gnt_idx   (w_rr_idx),
    .gnt_valid (w_rr_valid)
  );

`ifdef ENEMY_FIRE_AIMED_EN
  // Aimed mode: alive enemy whose launch x is nearest the player, lowest index on ties.
  always_comb begin
    logic [11:0] w_cx, w_dist, w_best;
    w_pick_idx   = 3'd0;
    w_pick_valid = 1'b0;
    w_best       = '1;
    w_cx         = '0;
    w_dist       = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      w_cx   = {1'b0, w_ex[i]} + 12'(X_OFFSET);
      w_dist = (w_cx >= {1'b0, player_x}) ? (w_cx - {1'b0, player_x})
                                          : ({1'b0, player_x} - w_cx);
      if (alive[i] && (!w_pick_valid || (w_dist < w_best))) begin
        w_pick_idx   = 3'(i);
        w_pick_valid = 1'b1;
        w_best       = w_dist;
      end
    end
  end
  assign w_unused = ^{w_rr_idx, w_rr_valid};
`else
  assign w_pick_idx   = w_rr_idx;
  assign w_pick_valid = w_rr_valid;
  assign w_unused     = ^player_x;
`endif

  // After an empty search, further attempts wait for a frame tick.
  assign w_pick_ok = w_pick_valid & (~r_retry | w_tick);

  // Lowest slot that is neither in flight nor inside its post-launch grace window.
  always_comb begin
    w_free_idx = 2'd0;
    w_slot_ok  = 1'b0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (!slot_busy[k] && (r_grace[k] == '0)) begin
        w_free_idx = 2'(k);
        w_slot_ok  = 1'b1;
      end
    end
  end

  assign w_sum_x = {1'b0, w_ex[r_src]} + 12'(X_OFFSET);
  assign w_sum_y = {1'b0, w_ey[r_src]} + 12'(Y_OFFSET);

  // State register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= COUNT;
    else     r_state <= w_state_next;
  end

  // Next-state and outputs; a level change abandons any pending shot.
  always_comb begin
    logic w_in_launch;
    w_state_next = r_state;
    w_in_launch  = (r_state == LAUNCH);
    case (r_state)
      COUNT:  if (!w_level_chg && w_tick && (r_counter == 8'd1)) w_state_next = PICK;
      PICK:   if (w_level_chg) w_state_next = COUNT;
              else if (w_pick_ok) w_state_next = SLOT;
      SLOT:   if (w_level_chg) w_state_next = COUNT;
              else if (w_slot_ok) w_state_next = LAUNCH;
      LAUNCH: w_state_next = COUNT;
      default: w_state_next = COUNT;
    endcase
    launch_valid = w_in_launch;
    fire_pending = (r_state == PICK) || (r_state == SLOT);
    launch_slot  = w_in_launch ? r_slot : 2'd0;
    launch_src   = w_in_launch ? r_src  : 3'd0;
    launch_x     = w_in_launch ? r_x    : '0;
    launch_y     = w_in_launch ? r_y    : '0;
  end

  // Frame counter, shooter/slot latches, coordinates and grace timers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_vsync_q <= 1'b0;
      r_level_q <= level_in;
      r_counter <= fire_interval(level_in, 8'(FIRE_BASE), 8'(FIRE_STEP), 8'(FIRE_MIN));
      r_ptr     <= 3'd4;
      r_src     <= 3'd0;
      r_slot    <= 2'd0;
      r_x       <= '0;
      r_y       <= '0;
      r_retry   <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) r_grace[k] <= '0;
    end else begin
      r_vsync_q <= vsync_in;
      r_level_q <= level_in;
      for (int k = 0; k < N_SLOTS; k++) begin
        if ((r_state == LAUNCH) && (r_slot == 2'(k))) r_grace[k] <= GW'(GRACE);
        else if (r_grace[k] != '0)                     r_grace[k] <= r_grace[k] - 1'b1;
      end
      case (r_state)
        COUNT: begin
          r_retry <= 1'b0;
          if (w_level_chg)                        r_counter <= w_interval;
          else if (w_tick && (r_counter != 8'd1)) r_counter <= r_counter - 8'd1;
        end
        PICK: begin
          if (w_level_chg) begin
            r_counter <= w_interval;
            r_retry   <= 1'b0;
          end else if (w_pick_ok) begin
            r_src   <= w_pick_idx;
            r_retry <= 1'b0;
          end else begin
            r_retry <= 1'b1;
          end
        end
        SLOT: begin
          if (w_level_chg) begin
            r_counter <= w_interval;
          end else if (w_slot_ok) begin
            r_slot <= w_free_idx;
            r_x    <= w_sum_x[11] ? {COORD_W{1'b1}} : w_sum_x[COORD_W-1:0];
            r_y    <= w_sum_y[11] ? {COORD_W{1'b1}} : w_sum_y[COORD_W-1:0];
          end
        end
        LAUNCH: begin
          r_ptr     <= r_src;
          r_counter <= w_interval;
        end
        default: r_counter <= w_interval;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_fire_sched
// Purpose  : Directed self-checking bench for enemy_fire_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_fire_sched;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync_in;
  logic [3:0]  level_in;
  logic [4:0]  alive;
  logic [54:0] en_xpos, en_ypos;
  logic [2:0]  slot_busy;
  logic [10:0] player_x;
  logic        launch_valid;
  logic [1:0]  launch_slot;
  logic [2:0]  launch_src;
  logic [10:0] launch_x, launch_y;
  logic        fire_pending;

  int n_checks   = 0;
  int n_errors   = 0;
  int launch_cnt = 0;
  int cnt_snap;
  bit seen;

  logic [10:0] ex [5];
  logic [10:0] ey [5];

  enemy_fire_sched dut (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .level_in     (level_in),
    .alive        (alive),
    .en_xpos      (en_xpos),
    .en_ypos      (en_ypos),
    .slot_busy    (slot_busy),
    .player_x     (player_x),
    .launch_valid (launch_valid),
    .launch_slot  (launch_slot),
    .launch_src   (launch_src),
    .launch_x     (launch_x),
    .launch_y     (launch_y),
    .fire_pending (fire_pending)
  );

  always #5 pclk = ~pclk;

  // Count launch pulses; sampled before the edge updates the state.
  always @(posedge pclk) if (launch_valid === 1'b1) launch_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] sat_add(input logic [10:0] a, input int off);
    int s;
    s = int'(a) + off;
    return (s > 2047) ? 11'd2047 : 11'(s);
  endfunction

  task automatic pack_pos();
    for (int i = 0; i < 5; i++) begin
      en_xpos[11*i +: 11] = ex[i];
      en_ypos[11*i +: 11] = ey[i];
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk) vsync_in = 1'b1;
      @(negedge pclk) vsync_in = 1'b0;
    end
  endtask

  task automatic wait_launch(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge pclk);
      if (launch_valid === 1'b1) got = 1'b1;
    end
  endtask

  // Issue n ticks, expect one launch from enemy src on slot sl within a short bound.
  task automatic shot(input string tag, input int n, input int src, input int sl);
    bit got;
    tick_n(n);
    wait_launch(4, got);
    check({tag, "_seen"}, 32'(got), 32'd1);
    check({tag, "_src"},  32'(launch_src),  32'(src));
    check({tag, "_slot"}, 32'(launch_slot), 32'(sl));
    check({tag, "_x"},    32'(launch_x), 32'(sat_add(ex[src], 16)));
    check({tag, "_y"},    32'(launch_y), 32'(sat_add(ey[src], 32)));
    @(negedge pclk);
    check({tag, "_one_cycle"}, 32'(launch_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; level_in = 4'd0; alive = 5'b11111;
    slot_busy = 3'b000; player_x = 11'd0;
    for (int i = 0; i < 5; i++) begin
      ex[i] = 11'(100 + 100 * i);
      ey[i] = 11'(50 + 10 * i);
    end
    pack_pos();
    repeat (3) @(negedge pclk);
    check("rst_valid",   32'(launch_valid), 32'd0);
    check("rst_pending", 32'(fire_pending), 32'd0);
    check("rst_fields",  32'({launch_slot, launch_src, launch_x, launch_y}), 32'd0);
    @(negedge pclk) rst = 1'b0;

    // First shot at level 0: 90th tick expires, launch two cycles later.
    tick_n(89);
    check("l0_no_early_pending", 32'(fire_pending), 32'd0);
    check("l0_no_early_launch",  32'(launch_cnt), 32'd0);
    tick_n(1);
    check("l0_pending_set", 32'(fire_pending), 32'd1);
    check("l0_c1_valid",    32'(launch_valid), 32'd0);
    @(negedge pclk);
    check("l0_c2_valid",    32'(launch_valid), 32'd0);
    @(negedge pclk);
    check("l0_c3_valid",    32'(launch_valid), 32'd1);
    check("l0_slot",        32'(launch_slot), 32'd0);
    check("l0_src",         32'(launch_src), 32'd0);
    check("l0_x",           32'(launch_x), 32'd116);
    check("l0_y",           32'(launch_y), 32'd82);
    @(negedge pclk);
    check("l0_pulse_end",   32'(launch_valid), 32'd0);
    check("l0_pending_clr", 32'(fire_pending), 32'd0);
    check("l0_once",        32'(launch_cnt), 32'd1);

    // Round-robin continues 1,2,3.
    shot("rr1", 90, 1, 0);
    shot("rr2", 90, 2, 0);
    shot("rr3", 90, 3, 0);

    // Level 9 clamps to 20 frames; level change in COUNT reloads.
    @(negedge pclk) level_in = 4'd9;
    @(negedge pclk);
    tick_n(19);
    check("l9_not_yet", 32'(fire_pending), 32'd0);
    shot("l9", 1, 4, 0);

    // Level 15 must not wrap: still 20.
    @(negedge pclk) level_in = 4'd15;
    @(negedge pclk);
    tick_n(19);
    check("l15_not_yet", 32'(fire_pending), 32'd0);
    shot("l15", 1, 0, 0);

    // ptr = 0, sparse alive mask skips dead enemies.
    alive = 5'b10100;
    shot("sparse_a", 20, 2, 0);
    shot("sparse_b", 20, 4, 0);

    // All slots busy: shot waits, then takes the released slot.
    alive = 5'b11111; slot_busy = 3'b111;
    tick_n(20);
    cnt_snap = launch_cnt;
    repeat (5) @(negedge pclk);
    check("busy_pending",   32'(fire_pending), 32'd1);
    check("busy_no_launch", 32'(launch_cnt), 32'(cnt_snap));
    slot_busy = 3'b101;
    wait_launch(3, seen);
    check("busy_rel_seen", 32'(seen), 32'd1);
    check("busy_rel_slot", 32'(launch_slot), 32'd1);
    check("busy_rel_src",  32'(launch_src), 32'd0);
    @(negedge pclk);
    slot_busy = 3'b010;
    shot("busy_next", 20, 1, 0);

    // Saturating launch x.
    slot_busy = 3'b000; alive = 5'b00001;
    ex[0] = 11'd2040; pack_pos();
    shot("sat", 20, 0, 0);
    check("sat_value", 32'(sat_add(ex[0], 16)), 32'd2047);

    // No enemy alive at expiry: hold pending until an enemy appears and a tick arrives.
    alive = 5'b00000;
    tick_n(20);
    cnt_snap = launch_cnt;
    repeat (4) @(negedge pclk);
    check("none_pending", 32'(fire_pending), 32'd1);
    alive = 5'b00010;
    repeat (4) @(negedge pclk);
    check("none_wait_tick", 32'(launch_cnt), 32'(cnt_snap));
    check("none_still_pend", 32'(fire_pending), 32'd1);
    shot("none_retry", 1, 1, 0);

    // Level change while waiting in SLOT drops the shot and reloads 50.
    alive = 5'b11111; slot_busy = 3'b111;
    tick_n(20);
    check("lvl_pending", 32'(fire_pending), 32'd1);
    cnt_snap = launch_cnt;
    @(negedge pclk) level_in = 4'd5;
    @(negedge pclk);
    check("lvl_dropped", 32'(fire_pending), 32'd0);
    slot_busy = 3'b000;
    tick_n(49);
    check("lvl_not_yet",   32'(fire_pending), 32'd0);
    check("lvl_no_launch", 32'(launch_cnt), 32'(cnt_snap));
    shot("lvl_reload", 1, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enemy_fire_sched.md
Name: enemy_fire_sched

Overview:
- Schedules enemy return fire for the five-enemy formation.
- Once per fire interval (counted in frames, shortened by level), picks one alive enemy round-robin and one free enemy-missile slot (3 slots).
- Issues a single-cycle launch command carrying slot index and launch coordinates.
- Sits beside the enemy formation. It consumes per-enemy lives/position and the slot busy flags from the enemy missile modules, and drives their launch inputs.

Parameters:
- FIRE_BASE, 90: frames between shots at level 0.
- FIRE_STEP, 8: frames removed per level.
- FIRE_MIN, 20: lower clamp on the interval.
- X_OFFSET, 16: added to enemy x to get the launch x (sprite centre).
- Y_OFFSET, 32: added to enemy y to get the launch y (sprite bottom).
- GRACE, 2: cycles a just-launched slot is treated busy regardless of slot_busy.

Ports:
- pclk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- vsync_in  in  1  vertical sync; its rising edge is the frame tick.
- level_in  in  4  current level.
- alive  in  5  bit i = enemy i+1 alive (lives flag).
- en_xpos  in  55  enemy x positions, 11 bits each; enemy i+1 at [11i+10:11i].
- en_ypos  in  55  enemy y positions, same packing.
- slot_busy  in  3  missile slot k in flight.
- player_x  in  11  player x; used only with the optional feature.
- launch_valid  out  1  one-cycle launch pulse.
- launch_slot  out  2  target slot 0..2.
- launch_src  out  3  source enemy 0..4.
- launch_x  out  11  launch x.
- launch_y  out  11  launch y.
- fire_pending  out  1  interval expired, shot not yet issued.

Behaviour:
- Reset: every output is 0. FSM goes to COUNT. Counter = interval(level_in). RR pointer = 4, so enemy 0 is searched first. Grace counters = 0.
- Reset mid-operation: an asserted launch_valid drops immediately; pending shot is discarded.
- Frame tick: vsync_in registered once; tick = vsync_in & ~vsync_q, one cycle.
- Interval: FIRE_BASE - level_in*FIRE_STEP, clamped to ≥ FIRE_MIN. Computed in 8-bit unsigned; a negative result also clamps to FIRE_MIN.
- COUNT:
  - Each tick decrements the counter.
  - A tick with counter == 1 goes to PICK and sets fire_pending.
- PICK:
  - Search alive starting at (ptr+1) mod 5, wrapping.
  - Found enemy e: latch e, go to SLOT.
  - None alive: stay in PICK with fire_pending = 1; retry on each following tick only.
- SLOT:
  - Lowest k with slot_busy[k] = 0 and grace[k] = 0 is the free slot.
  - Found: go to LAUNCH.
  - None: stay in SLOT; re-evaluate every cycle.
- LAUNCH, exactly one cycle:
  - launch_valid = 1; slot, src and coordinates held for that cycle.
  - ptr = e; grace[k] = GRACE.
  - fire_pending cleared; counter reloaded; back to COUNT.
- Latency: PICK→SLOT→LAUNCH takes 2 cycles minimum after the expiring tick.
- Coordinates are registered in SLOT from enemy e:
  - launch_x = x + X_OFFSET, launch_y = y + Y_OFFSET.
  - 12-bit add, saturating to 2047.
- Enemy e dies between PICK and LAUNCH: still launches (position already latched).
- Level change, level_in ≠ registered copy:
  - In COUNT: counter reloads with the new interval.
  - In PICK or SLOT: pending shot dropped, go to COUNT with reload.
  - Level change wins over a simultaneous tick.
- Tick while in PICK/SLOT/LAUNCH: ignored for counting.
- grace[k] decrements every cycle down to 0.

Optional Feature:
- Macro ENEMY_FIRE_AIMED_EN.
- Defined:
  - PICK chooses the alive enemy minimising |x_i + X_OFFSET - player_x|.
  - Ties go to the lowest index.
  - ptr is still updated but unused.
- Undefined: round-robin as above; player_x is ignored.

Decomposition:
- Package warblade_enemy_pkg holds:
  - N_ENEMIES = 5, N_SLOTS = 3, COORD_W = 11.
  - FSM state typedef (COUNT, PICK, SLOT, LAUNCH).
  - Interval computation function.
- Sub-module rr_pick5: combinational round-robin selector.
  - Inputs: req[4:0], ptr[2:0].
  - Outputs: gnt_idx[2:0], gnt_valid.
  - Instantiated once.

Test Plan:
- Reset, level 0, all alive, slots free, 90 ticks:
  - launch_valid pulses once, 2 cycles after the 90th tick.
  - slot 0, src 0, launch_x = en_x0+16, launch_y = en_y0+32.
- Four consecutive shots at level 0, all alive, slots free: src sequence 0,1,2,3.
- Shot 2 with alive = 5'b10100 and ptr = 0: src 2, then the next shot is src 4.
- Level 9:
  - Interval clamps to 20 (90-72 = 18 < 20).
  - Level 15: still 20; no wrap.
- slot_busy = 3'b111 at expiry:
  - fire_pending stays 1, no launch.
  - Release slot 1 → launch on slot 1 two cycles later.
  - A second consecutive shot never reuses a slot within GRACE cycles.
- Variants:
  - en_x0 = 2040: launch_x = 2047.
  - alive = 0 at expiry: pending held, no launch until a bit rises and a tick arrives.
  - level_in changes during SLOT: pending dropped, counter = new interval.
